// File: rtl/cap_regbus_pkg.sv
// Shared types and constants for the capture register-bus bridge.
package cap_regbus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrStb,
        StWrResp,
        StRdStb,
        StRdWait,
        StRdResp
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] BLOCK_ID_DEF = 4'd1;

    localparam logic [15:0] CAPADDR = 16'h0000;
    localparam logic [15:0] CAPCTRL = 16'h0004;
    localparam logic [15:0] CAPINT  = 16'h0008;
    localparam logic [15:0] CAPFIFO = 16'h000C;

    function automatic logic block_miss(input logic [3:0] sel, input logic [3:0] id);
        return sel != id;
    endfunction

endpackage

// File: rtl/cap_regbus_bridge.sv
// AXI4-Lite slave driving single-cycle WREN/RDEN strobes on the capture register bus.
// Define CAP_REGBUS_DECERR_EN to answer SLVERR for addresses outside BLOCK_ID.
module cap_regbus_bridge
    import cap_regbus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter logic [3:0]  BLOCK_ID = BLOCK_ID_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic [ADDR_W-1:0] WRADDR,
    output logic [3:0]        BYTEEN,
    output logic              WREN,
    output logic [31:0]       WDATA,
    output logic [ADDR_W-1:0] RDADDR,
    output logic              RDEN,
    input  logic [31:0]       RDATA
);

`ifdef CAP_REGBUS_DECERR_EN
    localparam bit DecErrEn = 1'b1;
`else
    localparam bit DecErrEn = 1'b0;
`endif

    localparam logic [1:0] LastCnt = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              wren_q, wren_d, rden_q, rden_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic              aw_hs, w_hs, ar_hs;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    state_d = StWrStb;
                    err_d   = DecErrEn && block_miss(awaddr_d[15:12], BLOCK_ID);
                end else if (ar_hs) begin
                    state_d  = StRdStb;
                    araddr_d = S_AXI_ARADDR;
                    err_d    = DecErrEn && block_miss(S_AXI_ARADDR[15:12], BLOCK_ID);
                end
            end
            StWrStb: state_d = StWrResp;
            StWrResp: begin
                if (S_AXI_BREADY) begin
                    state_d   = StIdle;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            StRdStb: begin
                state_d = StRdWait;
                cnt_d   = 2'd0;
            end
            StRdWait: begin
                if (cnt_q == LastCnt) begin
                    state_d = StRdResp;
                    rdata_d = err_q ? 32'h0 : RDATA;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StRdResp: begin
                if (S_AXI_RREADY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every bus-facing output is a flop loaded from the next state.
        wren_d    = (state_d == StWrStb) && !err_d;
        rden_d    = (state_d == StRdStb) && !err_d;
        bvalid_d  = (state_d == StWrResp);
        rvalid_d  = (state_d == StRdResp);
        bresp_d   = (bvalid_d && err_d) ? RESP_SLVERR : RESP_OKAY;
        rresp_d   = (rvalid_d && err_d) ? RESP_SLVERR : RESP_OKAY;
        awready_d = (state_d == StIdle) && !aw_held_d;
        wready_d  = (state_d == StIdle) && !w_held_d;
        arready_d = (state_d == StIdle) && !aw_held_d && !w_held_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StIdle;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
        end
    end

    // A pending AW/W this cycle blocks AR so writes win a simultaneous arrival.
    assign S_AXI_ARREADY = arready_q & ~S_AXI_AWVALID & ~S_AXI_WVALID;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign WREN          = wren_q;
    assign RDEN          = rden_q;
    assign WRADDR        = awaddr_q;
    assign WDATA         = wdata_q;
    assign BYTEEN        = wstrb_q;
    assign RDADDR        = araddr_q;

endmodule

// File: tb/tb_cap_regbus_bridge.sv
// Randomised self-checking bench for cap_regbus_bridge against a transaction-level model.
module tb_cap_regbus_bridge;
    import cap_regbus_pkg::*;

    localparam int unsigned RD_LAT = 1;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [15:0] S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [15:0] S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA = '0;

    cap_regbus_bridge #(
        .ADDR_W  (16),
        .RD_LAT  (RD_LAT),
        .BLOCK_ID(4'd1)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .WRADDR       (WRADDR),
        .BYTEEN       (BYTEEN),
        .WREN         (WREN),
        .WDATA        (WDATA),
        .RDADDR       (RDADDR),
        .RDEN         (RDEN),
        .RDATA        (RDATA)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: what the bus must show, derived from handshake cycles.
    bit          aw_seen, w_seen, wr_sched, b_pend, r_pend, wr_err, rd_err;
    int          wren_cyc = -1, rden_cyc = -1, b_from = 0, r_from = 0, rdata_cyc = -1;
    logic [15:0] m_awaddr, m_araddr;
    logic [31:0] m_wdata, exp_rdata, rdata_val;
    logic [3:0]  m_wstrb;
    logic [31:0] model_mem[4];
    logic [31:0] slave_mem[4];
    logic [15:0] offs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no handshake within cycle budget (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic bit exp_err(input logic [15:0] a);
`ifdef CAP_REGBUS_DECERR_EN
        return a[15:12] != 4'd1;
`else
        return a[15:12] == 4'hF && a[15:12] != 4'hF;
`endif
    endfunction

    // Register-bus slave: RDATA is only meaningful RD_LAT cycles after RDEN.
    initial forever begin
        @(posedge ACLK);
        cyc++;
        #1;
        RDATA = (cyc == rdata_cyc) ? rdata_val : $urandom;
    end

    // Compare process: check every cycle, then advance the model.
    initial forever begin
        @(negedge ACLK);
        if (!ARESETN) begin
            chk("reset_outputs", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                 S_AXI_RVALID, WREN, RDEN, S_AXI_BRESP, S_AXI_RRESP}), 32'h0);
            aw_seen = 0; w_seen = 0; wr_sched = 0; b_pend = 0; r_pend = 0;
            wren_cyc = -1; rden_cyc = -1; rdata_cyc = -1;
        end else begin
            bit e_wren, e_rden, e_bv, e_rv;
            e_wren = (cyc == wren_cyc) && !wr_err;
            e_rden = (cyc == rden_cyc) && !rd_err;
            e_bv   = b_pend && (cyc >= b_from);
            e_rv   = r_pend && (cyc >= r_from);
            chk("wren", 32'(WREN), 32'(e_wren));
            chk("rden", 32'(RDEN), 32'(e_rden));
            chk("bvalid", 32'(S_AXI_BVALID), 32'(e_bv));
            chk("rvalid", 32'(S_AXI_RVALID), 32'(e_rv));
            if (e_wren) begin
                chk("wraddr", 32'(WRADDR), 32'(m_awaddr));
                chk("wdata", WDATA, m_wdata);
                chk("byteen", 32'(BYTEEN), 32'(m_wstrb));
            end
            if (e_rden) chk("rdaddr", 32'(RDADDR), 32'(m_araddr));
            if (e_bv) chk("bresp", 32'(S_AXI_BRESP), wr_err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
            if (e_rv) begin
                chk("rdata", S_AXI_RDATA, exp_rdata);
                chk("rresp", 32'(S_AXI_RRESP), rd_err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
            end
            if (aw_seen || w_seen || r_pend || S_AXI_AWVALID || S_AXI_WVALID)
                chk("arready_blocked", 32'(S_AXI_ARREADY), 32'h0);
            if (aw_seen || r_pend) chk("awready_blocked", 32'(S_AXI_AWREADY), 32'h0);
            if (w_seen || r_pend) chk("wready_blocked", 32'(S_AXI_WREADY), 32'h0);

            if (WREN) slave_mem[WRADDR[3:2]] = merge(slave_mem[WRADDR[3:2]], WDATA, BYTEEN);
            if (RDEN) begin
                rdata_cyc = cyc + int'(RD_LAT);
                rdata_val = slave_mem[RDADDR[3:2]];
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_seen = 1; m_awaddr = S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_seen = 1; m_wdata = S_AXI_WDATA; m_wstrb = S_AXI_WSTRB;
            end
            if (aw_seen && w_seen && !wr_sched) begin
                wr_sched = 1; b_pend = 1;
                wren_cyc = cyc + 1; b_from = cyc + 2;
                wr_err = exp_err(m_awaddr);
                if (!wr_err)
                    model_mem[m_awaddr[3:2]] = merge(model_mem[m_awaddr[3:2]], m_wdata, m_wstrb);
            end
            if (S_AXI_BVALID && S_AXI_BREADY && e_bv) begin
                b_pend = 0; aw_seen = 0; w_seen = 0; wr_sched = 0;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                r_pend = 1; m_araddr = S_AXI_ARADDR;
                rden_cyc = cyc + 1; r_from = cyc + 2 + int'(RD_LAT);
                rd_err = exp_err(S_AXI_ARADDR);
                exp_rdata = rd_err ? 32'h0 : model_mem[S_AXI_ARADDR[3:2]];
            end
            if (S_AXI_RVALID && S_AXI_RREADY && e_rv) r_pend = 0;
        end
    end

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp, output int lat);
        int k = 0, nb = 0, hs_cyc = 0, b_cyc = -1;
        bit aw_done = 0, w_done = 0, b_done = 0;
        resp = 2'b11;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        while (!(aw_done && w_done) && k < 200) begin
            S_AXI_AWVALID = !aw_done && (k >= aw_dly);
            S_AXI_WVALID  = !w_done && (k >= w_dly);
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            hs_cyc = cyc;
            @(posedge ACLK); #1; k++;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        if (!(aw_done && w_done)) timeout("aw_w_handshake");
        k = 0;
        while (!b_done && k < 200) begin
            S_AXI_BREADY = (nb >= b_dly);
            @(negedge ACLK);
            if (S_AXI_BVALID) begin
                if (b_cyc < 0) b_cyc = cyc;
                if (S_AXI_BREADY) begin b_done = 1; resp = S_AXI_BRESP; end
                else nb++;
            end
            @(posedge ACLK); #1; k++;
        end
        S_AXI_BREADY = 0;
        if (!b_done) timeout("b_handshake");
        lat = b_cyc - hs_cyc;
    endtask

    task automatic do_read(input logic [15:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int k = 0, nr = 0, hs_cyc = 0, r_cyc = -1;
        bit ar_done = 0, r_done = 0;
        data = 32'hDEAD_BEEF; resp = 2'b11;
        S_AXI_ARADDR = addr;
        while (!ar_done && k < 200) begin
            S_AXI_ARVALID = (k >= ar_dly);
            @(negedge ACLK);
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_done = 1;
            hs_cyc = cyc;
            @(posedge ACLK); #1; k++;
        end
        S_AXI_ARVALID = 0;
        if (!ar_done) timeout("ar_handshake");
        k = 0;
        while (!r_done && k < 200) begin
            S_AXI_RREADY = (nr >= r_dly);
            @(negedge ACLK);
            if (S_AXI_RVALID) begin
                if (r_cyc < 0) r_cyc = cyc;
                if (S_AXI_RREADY) begin r_done = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
                else nr++;
            end
            @(posedge ACLK); #1; k++;
        end
        S_AXI_RREADY = 0;
        if (!r_done) timeout("r_handshake");
        lat = r_cyc - hs_cyc;
    endtask

    initial begin
        logic [1:0]  resp, rresp;
        logic [31:0] rd;
        int          lat, rlat;
        offs = '{CAPADDR, CAPCTRL, CAPINT, CAPFIFO};
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = 32'h0;
            slave_mem[i] = 32'h0;
        end
        model_mem[3] = 32'h3;
        slave_mem[3] = 32'h3;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK); ARESETN = 1'b1;
        @(posedge ACLK); #1;

        // AW and W together, full strobes.
        do_write(16'h1000 | CAPADDR, 32'h0123_4567, 4'hF, 0, 0, 0, resp, lat);
        chk("t1_bresp", 32'(resp), 32'h0);
        chk("t1_latency", 32'(lat), 32'd2);

        // W three cycles ahead of AW, single byte lane.
        do_write(16'h1000 | CAPCTRL, 32'hAABB_CCDD, 4'h1, 3, 0, 1, resp, lat);
        chk("t2_latency", 32'(lat), 32'd2);

        // Read with RREADY held off for four RVALID cycles.
        do_read(16'h1000 | CAPFIFO, 0, 4, rd, rresp, rlat);
        chk("t3_rdata", rd, 32'h3);
        chk("t3_latency", 32'(rlat), 32'd3);
        do_read(16'h1000 | CAPADDR, 0, 0, rd, rresp, rlat);
        chk("t1_readback", rd, 32'h0123_4567);
        do_read(16'h1000 | CAPCTRL, 0, 0, rd, rresp, rlat);
        chk("t2_readback", rd, 32'h0000_00DD);

        // AW, W and AR all in the same cycle.
        fork
            do_write(16'h1000 | CAPINT, 32'h5555_AAAA, 4'hC, 0, 0, 0, resp, lat);
            do_read(16'h1000 | CAPINT, 0, 0, rd, rresp, rlat);
        join
        chk("t4_rdata", rd, 32'h5555_0000);

        // Reset during the read wait.
        S_AXI_ARADDR = 16'h1000 | CAPINT;
        S_AXI_ARVALID = 1'b1;
        begin
            int k = 0;
            bit done = 0;
            while (!done && k < 50) begin
                @(negedge ACLK);
                done = S_AXI_ARREADY;
                @(posedge ACLK); #1; k++;
            end
            if (!done) timeout("t5_ar");
        end
        S_AXI_ARVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK); ARESETN = 1'b1;
        repeat (5) @(posedge ACLK);
        #1;
        do_read(16'h1000 | CAPINT, 0, 1, rd, rresp, rlat);
        chk("t5_after_reset", rd, 32'h5555_0000);

`ifdef CAP_REGBUS_DECERR_EN
        do_write(16'h2000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, lat);
        chk("t6_bresp", 32'(resp), 32'h2);
        chk("t6_latency", 32'(lat), 32'd2);
        do_read(16'h2000, 0, 0, rd, rresp, rlat);
        chk("t6_rdata", rd, 32'h0);
        chk("t6_rresp", 32'(rresp), 32'h2);
`endif

        for (int it = 0; it < 60; it++) begin
            logic [15:0] a;
            int          op;
            a = offs[$urandom_range(0, 3)];
            a[15:12] = ($urandom_range(0, 3) == 0) ? 4'h2 : 4'h1;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2), resp, lat);
            end else if (op == 1) begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), rd, rresp, rlat);
            end else begin
                fork
                    do_write(a, $urandom, 4'hF, 0, 0, $urandom_range(0, 2), resp, lat);
                    do_read(a, 0, $urandom_range(0, 2), rd, rresp, rlat);
                join
            end
        end

        repeat (5) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
